// File: rtl/multiplier_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplier_control.sv
// Sequencer for the shift-and-add multiplier: owns the FSM and the iteration down-counter.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   CALC  | one add/shift iteration per clock, counter counts n down to 0
//   DONE  | product valid and held; start reloads operands
module multiplier_control
    import multiplier_pkg::*;
#(
    parameter int n = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic load,
    output logic step
);

    localparam int cw = $clog2(n + 1);

    state_t          state;
    state_t          state_nxt;
    logic [cw-1:0]   cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= cw'(n);
        end else if (step) begin
            cnt <= cnt - cw'(1);
        end
    end

    // The last iteration is the one that takes the counter from 1 to 0.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt <= cw'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multiplier.sv
// Unsigned sequential shift-and-add multiplier: n iterations, one add+shift per clock.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int n = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [n-1:0]   M,
    input  logic [n-1:0]   Qin,
    output logic [2*n-1:0] AQ
);

    logic           load;
    logic           step;
    logic           c;
    logic [n-1:0]   a;
    logic [n-1:0]   q;
    logic [n-1:0]   mreg;
    logic [n:0]     sum;

    multiplier_control #(
        .n (n)
    ) u_control (
        .clock (clock),
        .reset (reset),
        .start (start),
        .load  (load),
        .step  (step)
    );

    always_comb begin
        sum = {c, a};
        if (q[0]) begin
            sum = {1'b0, a} + {1'b0, mreg};
        end
    end

    // Add result and right shift of {C,A,Q} land in the same edge; C refills with 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c    <= 1'b0;
            a    <= '0;
            q    <= '0;
            mreg <= '0;
        end else if (load) begin
            c    <= 1'b0;
            a    <= '0;
            q    <= Qin;
            mreg <= M;
        end else if (step) begin
            {c, a, q} <= {1'b0, sum, q[n-1:1]};
        end
    end

    assign AQ = {a, q};

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the n=4 multiplier.
module tb_multiplier;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] M;
    logic [3:0] Qin;
    logic [7:0] AQ;

    int total;
    int bad;

    multiplier #(
        .n (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .M     (M),
        .Qin   (Qin),
        .AQ    (AQ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic wait_neg(input int k);
        for (int i = 0; i < k; i++) @(negedge clock);
    endtask

    // One-cycle start pulse; returns on the negedge right after edge k+4.
    task automatic run(input logic [3:0] m, input logic [3:0] qv);
        @(negedge clock);
        M     = m;
        Qin   = qv;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_neg(4);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        M     = 4'd0;
        Qin   = 4'd0;
        #3;
        check("reset_aq", AQ, 8'd0);
        wait_neg(2);
        reset = 1'b0;

        // 3*5 at exact latency, then held for 8 more cycles
        run(4'd3, 4'd5);
        check("lat_3x5", AQ, 8'd15);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("hold_3x5", AQ, 8'd15);
        end

        run(4'd15, 4'd15);
        check("max_15x15", AQ, 8'd225);
        run(4'd0, 4'd9);
        check("zero_m", AQ, 8'd0);
        run(4'd9, 4'd0);
        check("zero_q", AQ, 8'd0);

        for (int mi = 0; mi < 16; mi++) begin
            for (int qi = 0; qi < 16; qi++) begin
                run(4'(mi), 4'(qi));
                wait_neg(4);
                check("sweep", AQ, 8'(mi * qi));
            end
        end

        // reset mid-CALC abandons, takes effect without a clock edge
        @(negedge clock);
        M     = 4'd7;
        Qin   = 4'd6;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_neg(2);
        reset = 1'b1;
        #1;
        check("reset_mid", AQ, 8'd0);
        wait_neg(2);
        check("reset_held", AQ, 8'd0);
        reset = 1'b0;
        run(4'd2, 4'd3);
        check("after_reset", AQ, 8'd6);

        // start and operand changes during CALC are ignored
        @(negedge clock);
        M     = 4'd5;
        Qin   = 4'd5;
        start = 1'b1;
        @(negedge clock);
        M   = 4'd1;
        Qin = 4'd1;
        wait_neg(2);
        start = 1'b0;
        wait_neg(2);
        check("calc_ignore", AQ, 8'd25);
        run(4'd1, 4'd1);
        check("restart_done", AQ, 8'd1);

        // start held high reloads in DONE each time; last load wins
        @(negedge clock);
        M     = 4'd6;
        Qin   = 4'd7;
        start = 1'b1;
        wait_neg(2);
        M   = 4'd9;
        Qin = 4'd11;
        wait_neg(10);
        start = 1'b0;
        wait_neg(8);
        check("held_start", AQ, 8'd99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
